echo_delay_ram_scheduler: RTL and testbench

//  Sequences one single-port synchronous RAM used as the stereo echo delay line.
//  Per accepted stereo pair it reads the L/R samples stored delay_samples pairs ago,

---
 rtl/echo_delay_ram_scheduler.sv | 157 +++++++++++++++
 tb/tb_echo_delay_ram_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_ram_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : echo_delay_ram_scheduler
// Description : Sequences one single-port synchronous RAM as a stereo echo
//               delay line. Each accepted pair reads the L/R samples stored
//               DELAY_SAMPLES pairs ago, overwrites those slots with the new
//               pair, advances a circular pointer and presents current plus
//               delayed pair to the mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_delay_ram_scheduler #(
  parameter int AUDIO_WIDTH   = 16,
  parameter int DELAY_SAMPLES = 1024,
  localparam int PTR_W        = $clog2(DELAY_SAMPLES),
  localparam int ADDR_W       = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [AUDIO_WIDTH-1:0] i_left,
  input  logic [AUDIO_WIDTH-1:0] i_right,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [AUDIO_WIDTH-1:0] o_left,
  output logic [AUDIO_WIDTH-1:0] o_right,
  output logic [AUDIO_WIDTH-1:0] o_delayed_left,
  output logic [AUDIO_WIDTH-1:0] o_delayed_right,
  output logic                   o_primed,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [AUDIO_WIDTH-1:0] ram_wdata,
  input  logic [AUDIO_WIDTH-1:0] ram_rdata
);

  // Last valid slot index; the pointer wraps to zero after it.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DELAY_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_L = 3'd1,
    RD_R = 3'd2,
    WR_L = 3'd3,
    WR_R = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   primed_q, primed_d;
  logic [AUDIO_WIDTH-1:0] cur_l_q, cur_l_d;
  logic [AUDIO_WIDTH-1:0] cur_r_q, cur_r_d;
  logic [AUDIO_WIDTH-1:0] dly_l_q, dly_l_d;
  logic [AUDIO_WIDTH-1:0] dly_r_q, dly_r_d;

  // State register; reset abandons any in-flight pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: pointer, primed flag, latched current and delayed pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q    <= '0;
      primed_q <= 1'b0;
      cur_l_q  <= '0;
      cur_r_q  <= '0;
      dly_l_q  <= '0;
      dly_r_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      primed_q <= primed_d;
      cur_l_q  <= cur_l_d;
      cur_r_q  <= cur_r_d;
      dly_l_q  <= dly_l_d;
      dly_r_q  <= dly_r_d;
    end
  end

  // Next-state, RAM sequencing and handshake outputs. RAM read data arrives
  // one cycle after its address, so each read is captured in the following state.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    primed_d  = primed_q;
    cur_l_d   = cur_l_q;
    cur_r_d   = cur_r_q;
    dly_l_d   = dly_l_q;
    dly_r_d   = dly_r_q;
    i_ready   = 1'b0;
    o_valid   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          cur_l_d = i_left;
          cur_r_d = i_right;
          state_d = RD_L;
        end
      end
      RD_L: begin
        ram_addr = {ptr_q, 1'b0};
        state_d  = RD_R;
      end
      RD_R: begin
        ram_addr = {ptr_q, 1'b1};
        dly_l_d  = ram_rdata;
        state_d  = WR_L;
      end
      WR_L: begin
        ram_addr  = {ptr_q, 1'b0};
        ram_we    = 1'b1;
        ram_wdata = cur_l_q;
        dly_r_d   = ram_rdata;
        state_d   = WR_R;
      end
      WR_R: begin
        ram_addr  = {ptr_q, 1'b1};
        ram_we    = 1'b1;
        ram_wdata = cur_r_q;
        if (ptr_q == PTR_LAST) begin
          ptr_d    = '0;
          primed_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
        state_d = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (o_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Delayed samples are meaningless until the line has wrapped once.
  assign o_left          = cur_l_q;
  assign o_right         = cur_r_q;
  assign o_delayed_left  = primed_q ? dly_l_q : '0;
  assign o_delayed_right = primed_q ? dly_r_q : '0;
  assign o_primed        = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_echo_delay_ram_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_echo_delay_ram_scheduler
// Description : Self-checking bench for echo_delay_ram_scheduler. Two
//               instances (3-pair and 1024-pair delay) each with a
//               1-cycle-latency RAM model and a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_delay_ram_scheduler;

  localparam int AW_A = 3;   // $clog2(3)+1
  localparam int AW_B = 11;  // $clog2(1024)+1

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] dl;
    logic [15:0] dr;
    logic        p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            a_iv, a_iready, a_ovalid, a_ordy, a_oprimed, a_we;
  logic [15:0]     a_il, a_ir, a_ol, a_or, a_odl, a_odr, a_wdata, a_rdata;
  logic [AW_A-1:0] a_addr;
  logic            b_iv, b_iready, b_ovalid, b_ordy, b_oprimed, b_we;
  logic [15:0]     b_il, b_ir, b_ol, b_or, b_odl, b_odr, b_wdata, b_rdata;
  logic [AW_B-1:0] b_addr;

  echo_delay_ram_scheduler #(.AUDIO_WIDTH(16), .DELAY_SAMPLES(3)) u_dut_a (
    .clk(clk), .reset(rst_n), .i_valid(a_iv), .i_ready(a_iready),
    .i_left(a_il), .i_right(a_ir), .o_valid(a_ovalid), .o_ready(a_ordy),
    .o_left(a_ol), .o_right(a_or), .o_delayed_left(a_odl), .o_delayed_right(a_odr),
    .o_primed(a_oprimed), .ram_addr(a_addr), .ram_we(a_we), .ram_wdata(a_wdata),
    .ram_rdata(a_rdata)
  );

  echo_delay_ram_scheduler #(.AUDIO_WIDTH(16), .DELAY_SAMPLES(1024)) u_dut_b (
    .clk(clk), .reset(rst_n), .i_valid(b_iv), .i_ready(b_iready),
    .i_left(b_il), .i_right(b_ir), .o_valid(b_ovalid), .o_ready(b_ordy),
    .o_left(b_ol), .o_right(b_or), .o_delayed_left(b_odl), .o_delayed_right(b_odr),
    .o_primed(b_oprimed), .ram_addr(b_addr), .ram_we(b_we), .ram_wdata(b_wdata),
    .ram_rdata(b_rdata)
  );

  // Single-port synchronous RAM models, read-old-data on write.
  logic [15:0] mem_a [8]    = '{default: '0};
  logic [15:0] mem_b [2048] = '{default: '0};
  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    if (a_we) mem_a[a_addr] <= a_wdata;
    b_rdata <= mem_b[b_addr];
    if (b_we) mem_b[b_addr] <= b_wdata;
  end

  // Scoreboard state: what each delay slot should hold, pointer, primed flag.
  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] sha_l [3]    = '{default: '0};
  logic [15:0] sha_r [3]    = '{default: '0};
  logic [15:0] shb_l [1024] = '{default: '0};
  logic [15:0] shb_r [1024] = '{default: '0};
  int          ma_ptr, mb_ptr;
  logic        ma_primed, mb_primed;

  int total = 0;
  int bad   = 0;

  task automatic test_reset();
    rst_n = 1'b0;
    a_iv = 1'b0; b_iv = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL rst_i_ready got=%b exp=1", a_iready); end
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL rst_o_valid got=%b exp=0", a_ovalid); end
    total++; if (a_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%b exp=0", a_we); end
    total++; if (a_oprimed !== 1'b0) begin bad++; $display("FAIL rst_o_primed got=%b exp=0", a_oprimed); end
    total++; if (a_ol !== 16'h0) begin bad++; $display("FAIL rst_o_left got=%h exp=0000", a_ol); end
    total++; if (b_oprimed !== 1'b0) begin bad++; $display("FAIL rst_b_o_primed got=%b exp=0", b_oprimed); end
    rst_n = 1'b1;
    qa.delete(); qb.delete();
    ma_ptr = 0; ma_primed = 1'b0; mb_ptr = 0; mb_primed = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one pair into DUT A, observe RAM activity up to o_valid, optionally
  // stall o_ready for 'hold' cycles, then compare against the scoreboard.
  task automatic pair_a(input logic [15:0] l, input logic [15:0] r, input int hold,
                        output int lat, output int nw,
                        output logic [AW_A-1:0] wa0, output logic [AW_A-1:0] wa1,
                        output logic [AW_A-1:0] ra0);
    exp_t e;
    int   k;
    logic [15:0] s_l, s_r, s_dl, s_dr;
    logic s_p;
    wa0 = '0; wa1 = '0; ra0 = '0; nw = 0; lat = 0;
    a_il = l; a_ir = r; a_iv = 1'b1;
    if (hold > 0) a_ordy = 1'b0;
    k = 0;
    while (!a_iready && k < 50) begin @(posedge clk); #1; k++; end
    total++;
    if (a_iready !== 1'b1) begin
      bad++; $display("FAIL a_accept timeout i_ready=%b exp=1", a_iready);
      a_iv = 1'b0; a_ordy = 1'b1; return;
    end
    @(posedge clk);
    e.l  = l; e.r = r;
    e.p  = ma_primed || (ma_ptr == 2);
    e.dl = e.p ? sha_l[ma_ptr] : 16'h0;
    e.dr = e.p ? sha_r[ma_ptr] : 16'h0;
    sha_l[ma_ptr] = l; sha_r[ma_ptr] = r;
    if (ma_ptr == 2) begin ma_ptr = 0; ma_primed = 1'b1; end else ma_ptr++;
    qa.push_back(e);
    #1;
    a_iv = 1'b0;
    ra0 = a_addr;
    while (!a_ovalid && lat < 20) begin
      if (a_we) begin
        if (nw == 0) wa0 = a_addr; else wa1 = a_addr;
        nw++;
      end
      @(posedge clk); #1; lat++;
    end
    total++;
    if (a_ovalid !== 1'b1) begin
      bad++; $display("FAIL a_out timeout o_valid=%b exp=1", a_ovalid);
      a_ordy = 1'b1; void'(qa.pop_front()); return;
    end
    if (hold > 0) begin
      s_l = a_ol; s_r = a_or; s_dl = a_odl; s_dr = a_odr; s_p = a_oprimed;
      a_iv = 1'b1; a_il = ~l; a_ir = ~r;
      repeat (hold) begin
        @(posedge clk); #1;
        total++;
        if ({a_ovalid, a_iready, a_we, a_ol, a_or, a_odl, a_odr, a_oprimed} !==
            {1'b1, 1'b0, 1'b0, s_l, s_r, s_dl, s_dr, s_p}) begin
          bad++;
          $display("FAIL a_hold got v=%b rdy=%b we=%b l=%h r=%h dl=%h dr=%h exp v=1 rdy=0 we=0 l=%h r=%h dl=%h dr=%h",
                   a_ovalid, a_iready, a_we, a_ol, a_or, a_odl, a_odr, s_l, s_r, s_dl, s_dr);
        end
      end
      a_ordy = 1'b1;
    end
    e = qa.pop_front();
    total++; if (a_ol !== e.l) begin bad++; $display("FAIL a_o_left got=%h exp=%h", a_ol, e.l); end
    total++; if (a_or !== e.r) begin bad++; $display("FAIL a_o_right got=%h exp=%h", a_or, e.r); end
    total++; if (a_odl !== e.dl) begin bad++; $display("FAIL a_o_delayed_left got=%h exp=%h", a_odl, e.dl); end
    total++; if (a_odr !== e.dr) begin bad++; $display("FAIL a_o_delayed_right got=%h exp=%h", a_odr, e.dr); end
    total++; if (a_oprimed !== e.p) begin bad++; $display("FAIL a_o_primed got=%b exp=%b", a_oprimed, e.p); end
    @(posedge clk); #1;
    a_iv = 1'b0;
    total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL a_back_to_idle i_ready=%b exp=1", a_iready); end
  endtask

  task automatic test_single_pair();
    int lat, nw;
    logic [AW_A-1:0] wa0, wa1, ra0;
    pair_a(16'h1111, 16'h2222, 0, lat, nw, wa0, wa1, ra0);
    total++; if (lat !== 4) begin bad++; $display("FAIL single_latency got=%0d exp=4", lat); end
    total++; if (nw !== 2) begin bad++; $display("FAIL single_nwrites got=%0d exp=2", nw); end
    total++; if (wa0 !== 3'd0) begin bad++; $display("FAIL single_waddr0 got=%0d exp=0", wa0); end
    total++; if (wa1 !== 3'd1) begin bad++; $display("FAIL single_waddr1 got=%0d exp=1", wa1); end
    total++; if (mem_a[0] !== 16'h1111 || mem_a[1] !== 16'h2222) begin
      bad++; $display("FAIL single_ram got=%h/%h exp=1111/2222", mem_a[0], mem_a[1]);
    end
  endtask

  task automatic test_wrap();
    int lat, nw;
    logic [AW_A-1:0] wa0, wa1, ra0;
    for (int n = 0; n < 4; n++) begin
      pair_a(16'h0100 + 16'(n), 16'h0200 + 16'(n), 0, lat, nw, wa0, wa1, ra0);
    end
    // P3 reused slot 0: its delayed pair is P0 and its writes land on 0/1.
    total++; if (wa0 !== 3'd0 || wa1 !== 3'd1) begin
      bad++; $display("FAIL wrap_waddr got=%0d/%0d exp=0/1", wa0, wa1);
    end
    total++; if (mem_a[0] !== 16'h0103 || mem_a[1] !== 16'h0203) begin
      bad++; $display("FAIL wrap_ram got=%h/%h exp=0103/0203", mem_a[0], mem_a[1]);
    end
  endtask

  task automatic test_backpressure();
    int lat, nw;
    logic [AW_A-1:0] wa0, wa1, ra0;
    pair_a(16'hA5A5, 16'h5A5A, 10, lat, nw, wa0, wa1, ra0);
    pair_a(16'hBEEF, 16'hCAFE, 0, lat, nw, wa0, wa1, ra0);
    total++; if (lat !== 4) begin bad++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_reset_mid_write();
    int lat, nw, k;
    logic [AW_A-1:0] wa0, wa1, ra0;
    a_il = 16'h7777; a_ir = 16'h8888; a_iv = 1'b1;
    k = 0;
    while (!a_iready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1; a_iv = 1'b0;      // RD_L
    @(posedge clk); #1;                   // RD_R
    @(posedge clk); #1;                   // WR_L
    total++; if (a_we !== 1'b1) begin bad++; $display("FAIL mid_wr_l ram_we got=%b exp=1", a_we); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (a_iready !== 1'b1 || a_ovalid !== 1'b0 || a_we !== 1'b0) begin
      bad++; $display("FAIL mid_reset got rdy=%b v=%b we=%b exp rdy=1 v=0 we=0", a_iready, a_ovalid, a_we);
    end
    total++; if (a_oprimed !== 1'b0) begin bad++; $display("FAIL mid_reset_primed got=%b exp=0", a_oprimed); end
    rst_n = 1'b1;
    sha_l[ma_ptr] = 16'h7777;            // left slot was written on the reset edge
    qa.delete(); ma_ptr = 0; ma_primed = 1'b0;
    @(posedge clk); #1;
    pair_a(16'h4444, 16'h5555, 0, lat, nw, wa0, wa1, ra0);
    total++; if (ra0 !== 3'd0) begin bad++; $display("FAIL post_reset_raddr got=%0d exp=0", ra0); end
    total++; if (wa0 !== 3'd0) begin bad++; $display("FAIL post_reset_waddr got=%0d exp=0", wa0); end
  endtask

  task automatic test_long_delay();
    exp_t e;
    int   k;
    for (int n = 0; n < 2048; n++) begin
      b_il = 16'(n); b_ir = 16'h8000 | 16'(n); b_iv = 1'b1;
      k = 0;
      while (!b_iready && k < 50) begin @(posedge clk); #1; k++; end
      total++;
      if (b_iready !== 1'b1) begin bad++; $display("FAIL b_accept timeout n=%0d i_ready=%b exp=1", n, b_iready); return; end
      @(posedge clk);
      e.l  = b_il; e.r = b_ir;
      e.p  = mb_primed || (mb_ptr == 1023);
      e.dl = e.p ? shb_l[mb_ptr] : 16'h0;
      e.dr = e.p ? shb_r[mb_ptr] : 16'h0;
      shb_l[mb_ptr] = b_il; shb_r[mb_ptr] = b_ir;
      if (mb_ptr == 1023) begin mb_ptr = 0; mb_primed = 1'b1; end else mb_ptr++;
      qb.push_back(e);
      #1; b_iv = 1'b0;
      k = 0;
      while (!b_ovalid && k < 20) begin @(posedge clk); #1; k++; end
      total++;
      if (b_ovalid !== 1'b1) begin bad++; $display("FAIL b_out timeout n=%0d o_valid=%b exp=1", n, b_ovalid); return; end
      e = qb.pop_front();
      total++;
      if ({b_ol, b_or, b_odl, b_odr, b_oprimed} !== {e.l, e.r, e.dl, e.dr, e.p}) begin
        bad++;
        $display("FAIL b_bundle n=%0d got l=%h r=%h dl=%h dr=%h p=%b exp l=%h r=%h dl=%h dr=%h p=%b",
                 n, b_ol, b_or, b_odl, b_odr, b_oprimed, e.l, e.r, e.dl, e.dr, e.p);
      end
      if (n >= 1024) begin
        total++;
        if (b_odl !== 16'(n - 1024) || b_odr !== (16'h8000 | 16'(n - 1024))) begin
          bad++; $display("FAIL b_delay n=%0d got=%h/%h exp=%h/%h", n, b_odl, b_odr,
                          16'(n - 1024), 16'h8000 | 16'(n - 1024));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_iv = 1'b0; a_il = '0; a_ir = '0; a_ordy = 1'b1;
    b_iv = 1'b0; b_il = '0; b_ir = '0; b_ordy = 1'b1;
    ma_ptr = 0; mb_ptr = 0; ma_primed = 1'b0; mb_primed = 1'b0;
    test_reset();
    test_single_pair();
    test_reset();
    test_wrap();
    test_backpressure();
    test_reset_mid_write();
    test_reset();
    test_long_delay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
